// File: rtl/butterfly_pipe_unit.sv
// Three-stage radix-2 DIT butterfly: even = A + B*W, odd = A - B*W on complex fixed point.
// Valid/ready with one global stall, round-half-up, optional scale-by-half, saturation and sticky overflow.
module butterfly_pipe_unit #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned FRACTION_BITS = 14,
    parameter int unsigned TAG_WIDTH     = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_1_real,
    input  logic [WIDTH-1:0]     in_1_imag,
    input  logic [WIDTH-1:0]     in_2_real,
    input  logic [WIDTH-1:0]     in_2_imag,
    input  logic [WIDTH-1:0]     twiddle_real,
    input  logic [WIDTH-1:0]     twiddle_imag,
    input  logic [TAG_WIDTH-1:0] in_tag,
    input  logic                 mode_inverse,
    input  logic                 scale_half,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     even_real,
    output logic [WIDTH-1:0]     even_imag,
    output logic [WIDTH-1:0]     odd_real,
    output logic [WIDTH-1:0]     odd_imag,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 ovf_flag,
    input  logic                 ovf_clear
);

    localparam int unsigned PW = 2 * WIDTH + 2;
    localparam int unsigned SW = WIDTH + 2;
    localparam logic [PW-1:0] RND = PW'(1) << (FRACTION_BITS - 1);

    function automatic logic [PW-1:0] sx(input logic [WIDTH:0] v);
        return {{(PW - WIDTH - 1){v[WIDTH]}}, v};
    endfunction

    // Round half up, then keep only the SW bits the adder stage works with.
    function automatic logic [SW-1:0] round_shift(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        r = p + RND;
        return r[FRACTION_BITS +: SW];
    endfunction

    function automatic logic [SW:0] combine(input logic [WIDTH-1:0] a, input logic [SW-1:0] p,
                                            input logic sub, input logic half);
        logic [SW-1:0] sum;
        logic [SW:0]   ext;
        sum = {{2{a[WIDTH-1]}}, a} + (sub ? (~p + SW'(1)) : p);
        ext = {sum[SW-1], sum};
        if (half) begin
            ext = $signed(ext + (SW + 1)'(1)) >>> 1;
        end
        return ext;
    endfunction

    // Returns {overflow, saturated value}.
    function automatic logic [WIDTH:0] saturate(input logic [SW:0] x);
        logic [3:0] top;
        top = x[SW:WIDTH-1];
        if (top == 4'b0000 || top == 4'b1111) begin
            return {1'b0, x[WIDTH-1:0]};
        end
        if (x[SW]) begin
            return {2'b11, {(WIDTH - 1){1'b0}}};
        end
        return {2'b10, {(WIDTH - 1){1'b1}}};
    endfunction

    logic adv;

    logic                 v1_q, v1_d;
    logic [WIDTH-1:0]     a1r_q, a1r_d, a1i_q, a1i_d, b1r_q, b1r_d, b1i_q, b1i_d, w1r_q, w1r_d;
    logic [WIDTH:0]       w1i_q, w1i_d;
    logic [TAG_WIDTH-1:0] tag1_q, tag1_d;
    logic                 half1_q, half1_d;

    logic                 v2_q, v2_d;
    logic [WIDTH-1:0]     a2r_q, a2r_d, a2i_q, a2i_d;
    logic [SW-1:0]        p2r_q, p2r_d, p2i_q, p2i_d;
    logic [TAG_WIDTH-1:0] tag2_q, tag2_d;
    logic                 half2_q, half2_d;

    logic                 ov_q, ov_d, ovf_q, ovf_d;
    logic [WIDTH-1:0]     er_q, er_d, ei_q, ei_d, or_q, or_d, oi_q, oi_d;
    logic [TAG_WIDTH-1:0] otag_q, otag_d;

    logic [WIDTH:0]       twi_ext;
    logic [PW-1:0]        pr_full, pi_full;
    logic [WIDTH:0]       er_s, ei_s, or_s, oi_s;
    logic                 sat_any;

    assign adv      = !ov_q || out_ready;
    assign in_ready = adv;

    assign twi_ext = {twiddle_imag[WIDTH-1], twiddle_imag};
    assign pr_full = sx({b1r_q[WIDTH-1], b1r_q}) * sx({w1r_q[WIDTH-1], w1r_q})
                   - sx({b1i_q[WIDTH-1], b1i_q}) * sx(w1i_q);
    assign pi_full = sx({b1r_q[WIDTH-1], b1r_q}) * sx(w1i_q)
                   + sx({b1i_q[WIDTH-1], b1i_q}) * sx({w1r_q[WIDTH-1], w1r_q});

    assign er_s    = saturate(combine(a2r_q, p2r_q, 1'b0, half2_q));
    assign ei_s    = saturate(combine(a2i_q, p2i_q, 1'b0, half2_q));
    assign or_s    = saturate(combine(a2r_q, p2r_q, 1'b1, half2_q));
    assign oi_s    = saturate(combine(a2i_q, p2i_q, 1'b1, half2_q));
    assign sat_any = er_s[WIDTH] | ei_s[WIDTH] | or_s[WIDTH] | oi_s[WIDTH];

    always_comb begin
        v1_d = v1_q;  a1r_d = a1r_q;  a1i_d = a1i_q;  b1r_d = b1r_q;  b1i_d = b1i_q;
        w1r_d = w1r_q;  w1i_d = w1i_q;  tag1_d = tag1_q;  half1_d = half1_q;
        v2_d = v2_q;  a2r_d = a2r_q;  a2i_d = a2i_q;  p2r_d = p2r_q;  p2i_d = p2i_q;
        tag2_d = tag2_q;  half2_d = half2_q;
        ov_d = ov_q;  er_d = er_q;  ei_d = ei_q;  or_d = or_q;  oi_d = oi_q;  otag_d = otag_q;
        if (adv) begin
            v1_d = in_valid;
            if (in_valid) begin
                a1r_d   = in_1_real;
                a1i_d   = in_1_imag;
                b1r_d   = in_2_real;
                b1i_d   = in_2_imag;
                w1r_d   = twiddle_real;
                w1i_d   = mode_inverse ? (~twi_ext + (WIDTH + 1)'(1)) : twi_ext;
                tag1_d  = in_tag;
                half1_d = scale_half;
            end
            v2_d = v1_q;
            if (v1_q) begin
                a2r_d   = a1r_q;
                a2i_d   = a1i_q;
                p2r_d   = round_shift(pr_full);
                p2i_d   = round_shift(pi_full);
                tag2_d  = tag1_q;
                half2_d = half1_q;
            end
            ov_d = v2_q;
            // Bubbles leave the output registers untouched.
            if (v2_q) begin
                er_d   = er_s[WIDTH-1:0];
                ei_d   = ei_s[WIDTH-1:0];
                or_d   = or_s[WIDTH-1:0];
                oi_d   = oi_s[WIDTH-1:0];
                otag_d = tag2_q;
            end
        end
        ovf_d = (ovf_q && !ovf_clear) || (adv && v2_q && sat_any);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            v1_q <= 1'b0;  a1r_q <= '0;  a1i_q <= '0;  b1r_q <= '0;  b1i_q <= '0;
            w1r_q <= '0;  w1i_q <= '0;  tag1_q <= '0;  half1_q <= 1'b0;
            v2_q <= 1'b0;  a2r_q <= '0;  a2i_q <= '0;  p2r_q <= '0;  p2i_q <= '0;
            tag2_q <= '0;  half2_q <= 1'b0;
            ov_q <= 1'b0;  er_q <= '0;  ei_q <= '0;  or_q <= '0;  oi_q <= '0;
            otag_q <= '0;  ovf_q <= 1'b0;
        end else begin
            v1_q <= v1_d;  a1r_q <= a1r_d;  a1i_q <= a1i_d;  b1r_q <= b1r_d;  b1i_q <= b1i_d;
            w1r_q <= w1r_d;  w1i_q <= w1i_d;  tag1_q <= tag1_d;  half1_q <= half1_d;
            v2_q <= v2_d;  a2r_q <= a2r_d;  a2i_q <= a2i_d;  p2r_q <= p2r_d;  p2i_q <= p2i_d;
            tag2_q <= tag2_d;  half2_q <= half2_d;
            ov_q <= ov_d;  er_q <= er_d;  ei_q <= ei_d;  or_q <= or_d;  oi_q <= oi_d;
            otag_q <= otag_d;  ovf_q <= ovf_d;
        end
    end

    assign out_valid = ov_q;
    assign even_real = er_q;
    assign even_imag = ei_q;
    assign odd_real  = or_q;
    assign odd_imag  = oi_q;
    assign out_tag   = otag_q;
    assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_butterfly_pipe_unit.sv
// Scoreboard bench for butterfly_pipe_unit (WIDTH=8, FRACTION_BITS=5): driver pushes expected
// results, a monitor pops and compares whenever an output transfer happens.
module tb_butterfly_pipe_unit;

    localparam int W  = 8;
    localparam int FB = 5;
    localparam int TW = 5;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic                 RST, in_valid, in_ready, mode_inverse, scale_half;
    logic                 out_valid, out_ready, ovf_flag, ovf_clear;
    logic signed [W-1:0]  in_1_real, in_1_imag, in_2_real, in_2_imag, twiddle_real, twiddle_imag;
    logic signed [W-1:0]  even_real, even_imag, odd_real, odd_imag;
    logic [TW-1:0]        in_tag, out_tag;

    butterfly_pipe_unit #(.WIDTH(W), .FRACTION_BITS(FB), .TAG_WIDTH(TW)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .in_1_real(in_1_real), .in_1_imag(in_1_imag), .in_2_real(in_2_real),
        .in_2_imag(in_2_imag), .twiddle_real(twiddle_real), .twiddle_imag(twiddle_imag),
        .in_tag(in_tag), .mode_inverse(mode_inverse), .scale_half(scale_half),
        .out_valid(out_valid), .out_ready(out_ready), .even_real(even_real),
        .even_imag(even_imag), .odd_real(odd_real), .odd_imag(odd_imag), .out_tag(out_tag),
        .ovf_flag(ovf_flag), .ovf_clear(ovf_clear)
    );

    typedef struct {
        int ar; int ai; int br; int bi; int wr; int wi; int tag; bit inv; bit half;
    } stim_t;
    typedef struct {
        int er; int ei; int odr; int odi; int tag; bit sat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint fin(longint x, bit half);
        return half ? ((x + 1) >>> 1) : x;
    endfunction

    function automatic longint clamp(longint x);
        longint hi, lo;
        hi = (64'sd1 <<< (W - 1)) - 1;
        lo = -(64'sd1 <<< (W - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // Complex arithmetic straight from the definition: B*W (or B*conj(W)), rounded half up.
    function automatic exp_t model(stim_t s);
        exp_t   e;
        longint wi, pr, pi, v[4];
        wi = s.inv ? -longint'(s.wi) : longint'(s.wi);
        pr = longint'(s.br) * s.wr - longint'(s.bi) * wi;
        pi = longint'(s.br) * wi + longint'(s.bi) * s.wr;
        pr = (pr + (64'sd1 <<< (FB - 1))) >>> FB;
        pi = (pi + (64'sd1 <<< (FB - 1))) >>> FB;
        v[0] = fin(s.ar + pr, s.half);
        v[1] = fin(s.ai + pi, s.half);
        v[2] = fin(s.ar - pr, s.half);
        v[3] = fin(s.ai - pi, s.half);
        e.sat = 1'b0;
        for (int k = 0; k < 4; k++) if (clamp(v[k]) != v[k]) e.sat = 1'b1;
        e.er  = int'(clamp(v[0]));
        e.ei  = int'(clamp(v[1]));
        e.odr = int'(clamp(v[2]));
        e.odi = int'(clamp(v[3]));
        e.tag = s.tag;
        return e;
    endfunction

    function automatic stim_t mk(int ar, int ai, int br, int bi, int wr, int wi, int tag,
                                 bit inv, bit half);
        stim_t s;
        s.ar = ar; s.ai = ai; s.br = br; s.bi = bi; s.wr = wr; s.wi = wi;
        s.tag = tag; s.inv = inv; s.half = half;
        return s;
    endfunction

    function automatic exp_t ex(int er, int ei, int odr, int odi, int tag, bit sat);
        exp_t e;
        e.er = er; e.ei = ei; e.odr = odr; e.odi = odi; e.tag = tag; e.sat = sat;
        return e;
    endfunction

    function automatic stim_t rnd_stim();
        return mk(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                  int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                  int'($urandom_range(64)) - 32, int'($urandom_range(64)) - 32,
                  int'($urandom_range(31)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    endfunction

    task automatic send(input stim_t s, input bit use_exp, input exp_t given);
        exp_t e;
        if (use_exp) e = given;
        else e = model(s);
        @(negedge CLK);
        in_1_real = W'(s.ar);  in_1_imag = W'(s.ai);
        in_2_real = W'(s.br);  in_2_imag = W'(s.bi);
        twiddle_real = W'(s.wr);  twiddle_imag = W'(s.wi);
        in_tag = TW'(s.tag);  mode_inverse = s.inv;  scale_half = s.half;
        in_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            #4;
            if (in_ready) begin
                sb.push_back(e);
                @(posedge CLK);
                return;
            end
            @(negedge CLK);
        end
        check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            in_valid = 1'b0;
        end
    endtask

    task automatic latency_check(input string name);
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            in_valid = 1'b0;
            #4;
            check(name, longint'(out_valid), longint'(k == 3));
        end
    endtask

    // Monitor: drives out_ready, checks holds during stalls, pops scoreboard on transfers.
    initial begin
        bit     pv, prd, prst;
        longint prev, cur;
        exp_t   e;
        pv = 0; prd = 0; prst = 0; prev = 0;
        forever begin
            @(negedge CLK);
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(1));
                default: out_ready = 1'b0;
            endcase
            #4;
            cur = longint'({even_real, even_imag, odd_real, odd_imag, out_tag});
            if (pv && !prd && prst) begin
                check("hold_valid", longint'(out_valid), 1);
                check("hold_data", cur, prev);
            end
            if (RST && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("even_real", even_real, e.er);
                    check("even_imag", even_imag, e.ei);
                    check("odd_real", odd_real, e.odr);
                    check("odd_imag", odd_imag, e.odi);
                    check("out_tag", out_tag, e.tag);
                    if (e.sat) check("ovf_after_sat", longint'(ovf_flag), 1);
                end
            end
            pv = out_valid; prd = out_ready; prst = RST; prev = cur;
        end
    end

    initial begin
        exp_t  nx;
        stim_t s;
        nx = ex(0, 0, 0, 0, 0, 0);
        RST = 1'b0; in_valid = 1'b0; ovf_clear = 1'b0; mode_inverse = 1'b0; scale_half = 1'b0;
        in_1_real = '0; in_1_imag = '0; in_2_real = '0; in_2_imag = '0;
        twiddle_real = '0; twiddle_imag = '0; in_tag = '0;

        repeat (2) @(negedge CLK);
        #4;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_ovf", longint'(ovf_flag), 0);
        check("rst_even_real", even_real, 0);
        check("rst_out_tag", out_tag, 0);
        @(negedge CLK);
        RST = 1'b1;
        #4;
        check("in_ready_after_rst", longint'(in_ready), 1);

        send(mk(32, 0, 32, 0, 32, 0, 3, 0, 0), 1, ex(64, 0, 0, 0, 3, 0));
        latency_check("basic_latency");
        check("basic_ovf", longint'(ovf_flag), 0);

        send(mk(0, 0, 32, 0, 0, -32, 4, 1, 0), 1, ex(0, 32, 0, -32, 4, 0));
        send(mk(0, 0, 32, 0, 0, -32, 5, 0, 0), 1, ex(0, -32, 0, 32, 5, 0));
        send(mk(0, 0, 1, 0, 16, 0, 6, 0, 0), 1, ex(1, 0, -1, 0, 6, 0));
        send(mk(0, 0, -1, 0, 16, 0, 7, 0, 0), 1, ex(0, 0, 0, 0, 7, 0));
        send(mk(96, 0, 96, 0, 32, 0, 8, 0, 1), 1, ex(96, 0, 0, 0, 8, 0));
        send(mk(0, 0, 1, 1, 0, -128, 9, 1, 0), 1, ex(-4, 4, 4, -4, 9, 0));
        idle(6);
        #4;
        check("ovf_no_sat", longint'(ovf_flag), 0);

        send(mk(96, 0, 96, 0, 32, 0, 10, 0, 0), 1, ex(127, 0, 0, 0, 10, 1));
        send(mk(-128, 0, -96, 0, 32, 0, 11, 0, 0), 1, ex(-128, 0, -32, 0, 11, 1));
        idle(6);
        #4;
        check("ovf_set", longint'(ovf_flag), 1);
        idle(3);
        #4;
        check("ovf_sticky", longint'(ovf_flag), 1);
        @(negedge CLK);
        ovf_clear = 1'b1;
        @(negedge CLK);
        ovf_clear = 1'b0;
        #4;
        check("ovf_cleared", longint'(ovf_flag), 0);

        // Backpressure: six tagged items into a stalled pipe.
        @(posedge CLK); #1;
        ready_mode = 2;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    s = rnd_stim();
                    s.tag = i;
                    send(s, 0, nx);
                end
                idle(1);
            end
            begin
                repeat (8) @(negedge CLK);
                #4;
                check("bp_in_ready_low", longint'(in_ready), 0);
                check("bp_out_valid", longint'(out_valid), 1);
                check("bp_head_tag", out_tag, 0);
                @(posedge CLK); #1;
                ready_mode = 0;
                for (int i = 0; i < 6; i++) begin
                    @(negedge CLK);
                    #4;
                    check("bp_stream_valid", longint'(out_valid), 1);
                    check("bp_stream_tag", out_tag, i);
                end
            end
        join
        idle(4);
        check("bp_drained", sb.size(), 0);

        // Reset with three butterflies in flight, the first one saturating.
        @(posedge CLK); #1;
        ready_mode = 2;
        send(mk(96, 0, 96, 0, 32, 0, 12, 0, 0), 0, nx);
        send(rnd_stim(), 0, nx);
        send(rnd_stim(), 0, nx);
        @(negedge CLK);
        in_valid = 1'b0;
        #4;
        check("pre_rst_ovf", longint'(ovf_flag), 1);
        check("pre_rst_valid", longint'(out_valid), 1);
        @(negedge CLK);
        RST = 1'b0;
        sb.delete();
        @(negedge CLK);
        RST = 1'b1;
        #4;
        check("mid_rst_valid", longint'(out_valid), 0);
        check("mid_rst_even_real", even_real, 0);
        check("mid_rst_odd_imag", odd_imag, 0);
        check("mid_rst_tag", out_tag, 0);
        check("mid_rst_ovf", longint'(ovf_flag), 0);
        @(posedge CLK); #1;
        ready_mode = 0;
        send(mk(10, -20, 30, 15, 32, 0, 13, 0, 0), 0, nx);
        latency_check("post_rst_latency");

        // Random traffic with random backpressure.
        @(posedge CLK); #1;
        ready_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) idle(int'($urandom_range(1, 3)));
            send(rnd_stim(), 0, nx);
        end
        idle(1);
        for (int n = 0; n < 400 && sb.size() != 0; n++) @(negedge CLK);
        check("final_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
